// File: rtl/instr_loader.sv
// Program loader: assembles big-endian 32-bit words from a byte stream and writes them to instruction memory.
// Latency: 4th byte accepted at edge t -> wr_en high for cycle t..t+1; at most one word per 5 cycles.
// Backpressure: byte_ready drops outside LEN_HI/LEN_LO/DATA (including the WRITE cycle); the producer holds its byte.
//
// Ports:
//   clk, reset (async active-low)  | start: one-cycle pulse beginning a load
//   byte_in/byte_valid/byte_ready  : stream in (LEN_HI, LEN_LO, then 4*N bytes, MSB first)
//   wr_en/wr_addr/wr_data          : instruction memory write port, one strobe per word
//   busy/done/error/cpu_hold       : load status; done and error are sticky until the next start
//   word_count                     : words written in the current or last load
module instr_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] DEPTH_N = 16'(DEPTH_WORDS);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  localparam bit          TO_EN   = (TIMEOUT != 0);

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [31:0] word_reg;
  logic [1:0]  byte_idx;
  logic [31:0] idle_cnt;
  logic        xfer;
  logic        load_start;
  logic        timeout_hit;
  logic [15:0] len_new;

  always_comb begin
    byte_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
    xfer        = byte_valid && byte_ready;
    // start is only honoured when no load is running
    load_start  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    // idle_cnt holds the number of idle edges so far; this edge would be number TIMEOUT
    timeout_hit = TO_EN && byte_ready && !xfer && (idle_cnt == TO_LAST);
    len_new     = {len[15:8], byte_in};
    state_nxt   = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer)             state_nxt = S_LEN_LO;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if (len_new == 16'd0)         state_nxt = S_DONE;
          else if (len_new > DEPTH_N)   state_nxt = S_ERR;
          else                          state_nxt = S_DATA;
        end else if (timeout_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_DATA: begin
        if (xfer && (byte_idx == 2'd3)) state_nxt = S_WRITE;
        else if (timeout_hit)           state_nxt = S_ERR;
      end
      S_WRITE: begin
        if ((word_count + 16'd1) == len) state_nxt = S_DONE;
        else                             state_nxt = S_DATA;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len        <= 16'd0;
      word_reg   <= 32'd0;
      byte_idx   <= 2'd0;
      idle_cnt   <= 32'd0;
      word_count <= 16'd0;
      wr_addr    <= BASE_ADDR;
    end else begin
      if (byte_ready) idle_cnt <= xfer ? 32'd0 : idle_cnt + 32'd1;
      else            idle_cnt <= 32'd0;

      if (load_start) begin
        word_count <= 16'd0;
        wr_addr    <= BASE_ADDR;
        byte_idx   <= 2'd0;
      end

      if (xfer) begin
        case (state)
          S_LEN_HI: len[15:8] <= byte_in;
          S_LEN_LO: begin
            len[7:0] <= byte_in;
            byte_idx <= 2'd0;
          end
          S_DATA: begin
            word_reg <= {word_reg[23:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
          end
          default: ;
        endcase
      end

      if (state == S_WRITE) begin
        word_count <= word_count + 16'd1;
        wr_addr    <= wr_addr + 32'd4;
      end
    end
  end

  // Status is a pure function of state, so done/error stay put until the next start.
  assign wr_en    = (state == S_WRITE);
  assign wr_data  = word_reg;
  assign busy     = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA) || (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign cpu_hold = (state != S_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: table-driven images plus directed sequences for timing corners.
module tb_instr_loader;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, wr_en, busy, done, error, cpu_hold;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  instr_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(64), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold), .word_count(word_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];

  // record every write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_a.push_back(wr_addr);
      wq_d.push_back(wr_data);
    end
  end

  typedef struct {
    logic [0:11][7:0] b;
    int               nb;
    bit               gap;
    int               nw;
    logic [1:0][31:0] ea;
    logic [1:0][31:0] ed;
    bit               e_done;
    bit               e_err;
    bit               e_hold;
    logic [15:0]      e_wc;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   cyc;
    logic rdy;
    byte_in    = b;
    byte_valid = 1'b1;
    cyc        = 0;
    do begin
      rdy = byte_ready;
      tick(1);
      cyc++;
    end while (!rdy && cyc < 100);
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_byte: byte %h not accepted within 100 cycles", b);
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_q();
    wq_a.delete();
    wq_d.delete();
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {a, 8'hC3, ~a, 8'(i * 3)};
  endfunction

  initial begin
    vt[0].b = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04, 8'h00, 8'h00};
    vt[0].nb = 10; vt[0].gap = 1'b0; vt[0].nw = 2;
    vt[0].ea[0] = 32'h0; vt[0].ed[0] = 32'h2008_0005;
    vt[0].ea[1] = 32'h4; vt[0].ed[1] = 32'hAC08_0004;
    vt[0].e_done = 1'b1; vt[0].e_err = 1'b0; vt[0].e_hold = 1'b0; vt[0].e_wc = 16'd2;

    vt[1] = vt[0];
    vt[1].gap = 1'b1;

    vt[2].b = '0; vt[2].nb = 2; vt[2].gap = 1'b0; vt[2].nw = 0;
    vt[2].ea = '0; vt[2].ed = '0;
    vt[2].e_done = 1'b1; vt[2].e_err = 1'b0; vt[2].e_hold = 1'b0; vt[2].e_wc = 16'd0;

    vt[3].b = '0; vt[3].b[1] = 8'h41; vt[3].nb = 2; vt[3].gap = 1'b0; vt[3].nw = 0;
    vt[3].ea = '0; vt[3].ed = '0;
    vt[3].e_done = 1'b0; vt[3].e_err = 1'b1; vt[3].e_hold = 1'b1; vt[3].e_wc = 16'd0;

    vt[4].b = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 48'h0};
    vt[4].nb = 6; vt[4].gap = 1'b1; vt[4].nw = 1;
    vt[4].ea = '0; vt[4].ed = '0; vt[4].ed[0] = 32'hDEAD_BEEF;
    vt[4].e_done = 1'b1; vt[4].e_err = 1'b0; vt[4].e_hold = 1'b0; vt[4].e_wc = 16'd1;

    // reset values, while held in reset and just after release
    tick(2);
    for (int r = 0; r < 2; r++) begin
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", wr_addr, 32'h0);
      chk("rst_wr_data", wr_data, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_word_count", 32'(word_count), 32'd0);
      reset = 1'b1;
      tick(1);
    end

    // table-driven images
    for (int v = 0; v < 5; v++) begin
      clear_q();
      start_pulse();
      chk($sformatf("v%0d_busy_start", v), 32'(busy), 32'd1);
      chk($sformatf("v%0d_hold_start", v), 32'(cpu_hold), 32'd1);
      for (int i = 0; i < vt[v].nb; i++) begin
        send_byte(vt[v].b[i]);
        if (vt[v].gap) begin
          byte_in = 8'h5A;
          tick(1);
        end
      end
      tick(2);
      chk($sformatf("v%0d_nwrites", v), 32'(wq_a.size()), 32'(vt[v].nw));
      for (int j = 0; j < vt[v].nw && j < wq_a.size(); j++) begin
        chk($sformatf("v%0d_addr%0d", v, j), wq_a[j], vt[v].ea[j]);
        chk($sformatf("v%0d_data%0d", v, j), wq_d[j], vt[v].ed[j]);
      end
      chk($sformatf("v%0d_done", v), 32'(done), 32'(vt[v].e_done));
      chk($sformatf("v%0d_error", v), 32'(error), 32'(vt[v].e_err));
      chk($sformatf("v%0d_cpu_hold", v), 32'(cpu_hold), 32'(vt[v].e_hold));
      chk($sformatf("v%0d_word_count", v), 32'(word_count), 32'(vt[v].e_wc));
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_byte_ready", v), 32'(byte_ready), 32'd0);
    end

    // start while busy is ignored; exact write latency and cpu_hold release
    clear_q();
    start_pulse();
    send_byte(8'h00);
    start_pulse();
    send_byte(8'h01);
    send_word(32'h1122_3344);
    chk("lat_wr_en", 32'(wr_en), 32'd1);
    chk("lat_wr_data", wr_data, 32'h1122_3344);
    chk("lat_wr_addr", wr_addr, 32'h0);
    chk("lat_byte_ready", 32'(byte_ready), 32'd0);
    chk("lat_hold", 32'(cpu_hold), 32'd1);
    tick(1);
    chk("lat_wr_en_off", 32'(wr_en), 32'd0);
    chk("lat_done", 32'(done), 32'd1);
    chk("lat_hold_off", 32'(cpu_hold), 32'd0);
    chk("lat_wc", 32'(word_count), 32'd1);
    chk("lat_nwrites", 32'(wq_a.size()), 32'd1);

    // start coincident with a byte in DONE: the byte must not be taken
    clear_q();
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    tick(1);
    start      = 1'b0;
    byte_valid = 1'b0;
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hCAFE_BABE);
    tick(2);
    chk("coin_nwrites", 32'(wq_a.size()), 32'd1);
    if (wq_d.size() > 0) chk("coin_data", wq_d[0], 32'hCAFE_BABE);
    chk("coin_done", 32'(done), 32'd1);

    // timeout after a partial word
    clear_q();
    start_pulse();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h20);
    send_byte(8'h08);
    tick(TO - 1);
    chk("to_error_early", 32'(error), 32'd0);
    chk("to_busy_early", 32'(busy), 32'd1);
    tick(1);
    chk("to_error", 32'(error), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_hold", 32'(cpu_hold), 32'd1);
    chk("to_byte_ready", 32'(byte_ready), 32'd0);
    chk("to_wc", 32'(word_count), 32'd0);
    tick(3);
    chk("to_nwrites", 32'(wq_a.size()), 32'd0);

    // full-depth image: N == DEPTH_WORDS is accepted
    clear_q();
    start_pulse();
    send_byte(8'h00);
    send_byte(8'h40);
    for (int i = 0; i < 64; i++) send_word(pat(i));
    tick(2);
    chk("full_nwrites", 32'(wq_a.size()), 32'd64);
    for (int i = 0; i < 64 && i < wq_a.size(); i++) begin
      if (wq_a[i] !== 32'(4 * i) || wq_d[i] !== pat(i))
        chk($sformatf("full_word%0d", i), wq_d[i] ^ wq_a[i], pat(i) ^ 32'(4 * i));
    end
    n_cmp++;
    chk("full_last_addr", (wq_a.size() == 64) ? wq_a[63] : 32'hFFFF_FFFF, 32'd252);
    chk("full_done", 32'(done), 32'd1);
    chk("full_wc", 32'(word_count), 32'd64);

    // reset mid-load after one word written, then reload a 1-word image
    clear_q();
    start_pulse();
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'h0102_0304);
    tick(1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("mid_first_write", 32'(wq_a.size()), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_hold", 32'(cpu_hold), 32'd1);
    chk("mid_wc", 32'(word_count), 32'd0);
    chk("mid_wr_addr", wr_addr, 32'h0);
    chk("mid_byte_ready", 32'(byte_ready), 32'd0);
    tick(1);
    reset = 1'b1;
    tick(1);
    clear_q();
    start_pulse();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h0800_0000);
    tick(2);
    chk("mid_nwrites", 32'(wq_a.size()), 32'd1);
    if (wq_a.size() > 0) begin
      chk("mid_addr", wq_a[0], 32'h0);
      chk("mid_data", wq_d[0], 32'h0800_0000);
    end
    chk("mid_done", 32'(done), 32'd1);
    chk("mid_hold_off", 32'(cpu_hold), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
